sar_search4: RTL
================

Name: sar_search4

Overview:
- Successive-approximation search controller, the driving end of the magnitude-comparator interface.
- Presents trial values to an external comparator, consuming its gt/lt/eq flags, and converges MSB-first on an unknown target value.
- Used to recover a hidden operand, e.g. a threshold or a code held behind a compare-only port, in WIDTH probe cycles.
- Sits between a control FSM issuing `start` and a combinational comparator whose `b` input is the unknown target.

Parameters:
- WIDTH, 4, width of trial/result; search takes at most WIDTH probe cycles.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a search; sampled only in IDLE
- trial  out  WIDTH  registered value driven to comparator `a` input
- cmp_gt  in  1  comparator: trial > target (combinational from trial)
- cmp_lt  in  1  comparator: trial < target
- cmp_eq  in  1  comparator: trial == target
- busy  out  1  high in PROBE
- done  out  1  one-cycle pulse when result is valid
- result  out  WIDTH  recovered target, held until next done
- err  out  1  illegal comparator code seen in last search; valid with done, held until next start

Behaviour:
- Reset (async assert, sync release): state=IDLE, trial=0, busy=0, done=0, result=0, err=0, bit index=WIDTH-1.
- States: IDLE, PROBE, DONE.
- IDLE:
  - On start=1, next edge loads trial={1,0...0}, idx=WIDTH-1, err=0, and moves to PROBE.
  - start=0 holds all registers.
- PROBE (one cycle per bit), sampling cmp_* against the current registered trial:
  - cmp_gt only: clear trial[idx].
  - cmp_lt only or cmp_eq only: keep trial[idx].
  - If idx>0: set trial[idx-1], decrement idx, and stay in PROBE.
  - If idx==0: load result with the updated trial, then go to DONE.
  - Illegal code (zero or more than one flag high): err=1, result=current trial unmodified, go to DONE immediately.
- DONE: done=1 and busy=0 for exactly this cycle; return to IDLE. start in DONE is ignored.
- start while busy or in DONE is ignored; no queuing.
- Latency: start edge to done pulse = WIDTH+1 cycles (WIDTH probes + DONE). Throughput: new start accepted in the cycle after done.
- Result exactness: for any target in 0..2^WIDTH-1 with a legal comparator, result==target after the full search.
- Reset mid-search: immediate return to IDLE with reset values; done is not pulsed.
- trial holds its last value in IDLE and DONE.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN
- Defined: cmp_eq in PROBE loads result=current trial and goes to DONE at once, skipping the remaining bits. Latency = (probes used)+1, minimum 2 cycles.
- Undefined: cmp_eq is treated as "keep bit" and all WIDTH probes always run, giving fixed latency WIDTH+1.
- Result is identical either way.

Decomposition:
- Shared package sar_pkg holds:
  - the state enum (IDLE, PROBE, DONE);
  - default WIDTH constant;
  - a 3-bit comparator-code typedef {gt,lt,eq} with constants CMP_GT=3'b100, CMP_LT=3'b010, CMP_EQ=3'b001;
  - a function flagging illegal codes.
- No sub-module: datapath is one trial register, one index counter and the FSM.
- The bench instantiates the existing 4-bit comparator as the target model with a=trial, b=target; it is not part of this block.

Test Plan:
- Reset, then target=5, start pulse:
  - trial sequence 1000, 0100, 0110, 0101;
  - done at cycle 5 after start, result=0101, err=0;
  - with SAR_EARLY_EXIT_EN the sequence is identical (eq on 4th probe).
- Target=8, start:
  - without macro, 4 probes (1000,1100,1010,1001), result=1000, done at cycle 5;
  - with macro, done at cycle 2 after a single probe 1000.
- Sweep target 0..15, back-to-back starts the cycle after each done: every result==target, and target=15 yields probes 1000, 1100, 1110, 1111.
- Comparator forced to code 3'b000 on the 2nd probe (target=5): err=1, result=0100, done at cycle 3; the next start clears err.
- Assert rst_n low during the 3rd probe: all outputs 0 within the reset; no done pulse; a fresh start after release completes normally.
- start held high for 10 cycles: exactly one search per IDLE entry; pulses during PROBE/DONE are ignored; busy never overlaps done.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search block.
// Holds the FSM state encoding, the default search width and the
// {gt,lt,eq} comparator-code type with its legal one-hot values.
package sar_pkg;

    localparam int SAR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } sar_state_e;

    // Comparator flags packed as {gt, lt, eq}
    typedef logic [2:0] cmp_code_t;

    localparam cmp_code_t CMP_GT = 3'b100;
    localparam cmp_code_t CMP_LT = 3'b010;
    localparam cmp_code_t CMP_EQ = 3'b001;

    // A healthy comparator raises exactly one flag; anything else is illegal
    function automatic logic cmp_illegal(input cmp_code_t code);
        return !((code == CMP_GT) || (code == CMP_LT) || (code == CMP_EQ));
    endfunction

endpackage

// File: rtl/sar_search4.sv
// Successive-approximation search controller. Drives a trial value to an
// external comparator whose other operand is the unknown target, and
// converges MSB-first on that target in WIDTH probe cycles.
//
// Optional feature macro: SAR_EARLY_EXIT_EN
//   defined   - an eq flag during a probe finishes the search at once
//   undefined - eq is treated as "keep bit"; all WIDTH probes always run
//
// Handshake: start is a request sampled only in IDLE; a high start there
// launches one search on the next edge. start in PROBE or DONE is dropped,
// nothing is queued. done is a one-cycle pulse with result and err valid;
// result holds until the next done, err holds until the next start.
// busy is high exactly while probing and never overlaps done.
module sar_search4
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]    IDX_TOP    = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TRIAL_INIT = WIDTH'(1) << (WIDTH - 1);

    sar_state_e    state;
    logic [IW-1:0] idx;

    cmp_code_t        code;
    logic             code_bad;
    logic             early_hit;
    logic [WIDTH-1:0] kept_trial;
    logic [WIDTH-1:0] next_trial;

    assign code      = {cmp_gt, cmp_lt, cmp_eq};
    assign code_bad  = cmp_illegal(code);
    assign dbg_state = state;

`ifdef SAR_EARLY_EXIT_EN
    assign early_hit = (code == CMP_EQ);
`else
    assign early_hit = 1'b0;
`endif

    // Decide the current bit from the comparator, then tentatively set the next lower bit
    always_comb begin
        kept_trial = trial;
        if (code == CMP_GT) begin
            kept_trial[idx] = 1'b0;
        end
        next_trial = kept_trial;
        if (idx != '0) begin
            next_trial[idx - IW'(1)] = 1'b1;
        end
    end

    // Search FSM with registered trial, index and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            trial  <= '0;
            idx    <= IDX_TOP;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        trial <= TRIAL_INIT;
                        idx   <= IDX_TOP;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    if (code_bad) begin
                        // Comparator misbehaved: report the trial as it stood
                        err    <= 1'b1;
                        result <= trial;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (early_hit) begin
                        result <= trial;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (idx == '0) begin
                        trial  <= kept_trial;
                        result <= kept_trial;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        trial <= next_trial;
                        idx   <= idx - IW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
